// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries decoded operands, register specifiers and
// control from decode into execute, with flush, stall and load-use bubble.
// Latency 1 cycle. Priority: reset > flush > stall > load-use bubble > load.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_valid, i_stall, i_flush: decode valid, downstream hold, squash
//   i_pc, i_rs_data, i_rt_data, i_ext_imm (NBITS): datapath words in
//   i_rs_addr, i_rt_addr, i_rd_addr (5): register specifiers in
//   i_ctrl (CTRL_BITS): control bundle, bit0 = mem_read, bit1 = reg_write
//   o_*: registered copies of the above, plus o_valid
//   o_load_use: combinational load-use hazard; upstream holds PC and IF/ID
//   o_dbg_count (32): valid-load counter, only when ID_EX_DEBUG_EN is defined
module id_ex_reg #(
  parameter int NBITS     = 32,
  parameter int CTRL_BITS = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [NBITS-1:0]     i_pc,
  input  logic [NBITS-1:0]     i_rs_data,
  input  logic [NBITS-1:0]     i_rt_data,
  input  logic [NBITS-1:0]     i_ext_imm,
  input  logic [4:0]           i_rs_addr,
  input  logic [4:0]           i_rt_addr,
  input  logic [4:0]           i_rd_addr,
  input  logic [CTRL_BITS-1:0] i_ctrl,
  output logic [NBITS-1:0]     o_pc,
  output logic [NBITS-1:0]     o_rs_data,
  output logic [NBITS-1:0]     o_rt_data,
  output logic [NBITS-1:0]     o_ext_imm,
  output logic [4:0]           o_rs_addr,
  output logic [4:0]           o_rt_addr,
  output logic [4:0]           o_rd_addr,
  output logic [CTRL_BITS-1:0] o_ctrl,
  output logic                 o_valid,
`ifdef ID_EX_DEBUG_EN
  output logic [31:0]          o_dbg_count,
`endif
  output logic                 o_load_use
);

  logic [NBITS-1:0]     pc_q, pc_d;
  logic [NBITS-1:0]     rs_data_q, rs_data_d;
  logic [NBITS-1:0]     rt_data_q, rt_data_d;
  logic [NBITS-1:0]     ext_imm_q, ext_imm_d;
  logic [4:0]           rs_addr_q, rs_addr_d;
  logic [4:0]           rt_addr_q, rt_addr_d;
  logic [4:0]           rd_addr_q, rd_addr_d;
  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic                 valid_q, valid_d;
  logic                 load_use;
  logic                 load_en;

  // A load in EX whose destination ($rt) is a source of the instruction in
  // decode. $zero is never a real dependency.
  assign load_use = valid_q && ctrl_q[0] && i_valid && (rt_addr_q != 5'd0) &&
                    ((rt_addr_q == i_rs_addr) || (rt_addr_q == i_rt_addr));

  // Normal capture: no flush, no stall, no bubble (reset handled in the flop).
  assign load_en = !i_flush && !i_stall && !load_use;

  always_comb begin
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    ext_imm_d = ext_imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    if (i_flush) begin
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      ext_imm_d = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      ctrl_d    = '0;
      valid_d   = 1'b0;
    end else if (i_stall) begin
      // hold everything; load_use may still be high but must not disturb state
    end else if (load_use) begin
      // Bubble: kill control only; data fields are don't-care downstream and
      // are simply held.
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else begin
      pc_d      = i_pc;
      rs_data_d = i_rs_data;
      rt_data_d = i_rt_data;
      ext_imm_d = i_ext_imm;
      rs_addr_d = i_rs_addr;
      rt_addr_d = i_rt_addr;
      rd_addr_d = i_rd_addr;
      // A non-valid slot must never carry live control into execute.
      ctrl_d    = i_valid ? i_ctrl : '0;
      valid_d   = i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      ext_imm_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      ext_imm_q <= ext_imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
    end
  end

`ifdef ID_EX_DEBUG_EN
  logic [31:0] dbg_count_q, dbg_count_d;

  // Counts only edges that capture a valid instruction; wraps naturally.
  always_comb begin
    dbg_count_d = dbg_count_q;
    if (load_en && i_valid) dbg_count_d = dbg_count_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) dbg_count_q <= '0;
    else          dbg_count_q <= dbg_count_d;
  end

  assign o_dbg_count = dbg_count_q;
`endif

  assign o_pc       = pc_q;
  assign o_rs_data  = rs_data_q;
  assign o_rt_data  = rt_data_q;
  assign o_ext_imm  = ext_imm_q;
  assign o_rs_addr  = rs_addr_q;
  assign o_rt_addr  = rt_addr_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_ctrl     = ctrl_q;
  assign o_valid    = valid_q;
  assign o_load_use = load_use;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_stall, i_flush;
  logic [31:0] i_pc, i_rs_data, i_rt_data, i_ext_imm;
  logic [4:0]  i_rs_addr, i_rt_addr, i_rd_addr;
  logic [11:0] i_ctrl;
  logic [31:0] o_pc, o_rs_data, o_rt_data, o_ext_imm;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic [11:0] o_ctrl;
  logic        o_valid, o_load_use;
`ifdef ID_EX_DEBUG_EN
  logic [31:0] o_dbg_count;
`endif

  int errors = 0;
  int checks = 0;

  id_ex_reg #(.NBITS(32), .CTRL_BITS(12)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_pc(i_pc), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_ext_imm(i_ext_imm), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .i_rd_addr(i_rd_addr), .i_ctrl(i_ctrl),
    .o_pc(o_pc), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_ext_imm(o_ext_imm), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rd_addr(o_rd_addr), .o_ctrl(o_ctrl), .o_valid(o_valid),
`ifdef ID_EX_DEBUG_EN
    .o_dbg_count(o_dbg_count),
`endif
    .o_load_use(o_load_use)
  );

  always #5 i_clk = ~i_clk;

  // Reference view of the pipeline slot: what execute should currently see.
  typedef struct {
    logic [31:0] pc, rs_data, rt_data, ext_imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [11:0] ctrl;
    logic        valid;
    bit          data_known; // false after a bubble: data fields are don't-care
  } slot_t;

  slot_t m;
  int unsigned m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    // Execute holds a valid load writing rt, and decode reads that register.
    return m.valid && m.ctrl[0] && i_valid && (m.rt_addr != 0) &&
           (m.rt_addr == i_rs_addr || m.rt_addr == i_rt_addr);
  endfunction

  task automatic model_clear();
    m = '{pc:0, rs_data:0, rt_data:0, ext_imm:0, rs_addr:0, rt_addr:0,
          rd_addr:0, ctrl:0, valid:0, data_known:1};
  endtask

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (!i_reset) begin
      model_clear();
      m_count = 0;
    end else if (i_flush) begin
      model_clear();
    end else if (i_stall) begin
      // unchanged
    end else if (hz) begin
      m.valid = 0;
      m.ctrl = 0;
      m.data_known = 0;
    end else begin
      m.pc = i_pc; m.rs_data = i_rs_data; m.rt_data = i_rt_data;
      m.ext_imm = i_ext_imm; m.rs_addr = i_rs_addr; m.rt_addr = i_rt_addr;
      m.rd_addr = i_rd_addr; m.valid = i_valid;
      m.ctrl = i_valid ? i_ctrl : 12'd0;
      m.data_known = 1;
      if (i_valid) m_count++;
    end
  endtask

  task automatic compare_outputs();
    check("valid", o_valid, m.valid);
    check("ctrl", o_ctrl, m.ctrl);
    if (m.data_known) begin
      check("pc", o_pc, m.pc);
      check("rs_data", o_rs_data, m.rs_data);
      check("rt_data", o_rt_data, m.rt_data);
      check("ext_imm", o_ext_imm, m.ext_imm);
      check("rs_addr", o_rs_addr, m.rs_addr);
      check("rt_addr", o_rt_addr, m.rt_addr);
      check("rd_addr", o_rd_addr, m.rd_addr);
    end
`ifdef ID_EX_DEBUG_EN
    check("dbg_count", o_dbg_count, m_count);
`endif
  endtask

  // Inputs are already driven (away from the edge); check the combinational
  // hazard flag, clock once, then check registered outputs.
  task automatic step();
    #1;
    check("load_use", o_load_use, model_hazard());
    model_edge();
    @(posedge i_clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle_inputs();
    i_reset = 1; i_valid = 0; i_stall = 0; i_flush = 0;
    i_pc = 0; i_rs_data = 0; i_rt_data = 0; i_ext_imm = 0;
    i_rs_addr = 0; i_rt_addr = 0; i_rd_addr = 0; i_ctrl = 0;
  endtask

  task automatic rand_data();
    i_pc = $urandom; i_rs_data = $urandom; i_rt_data = $urandom;
    i_ext_imm = $urandom; i_rd_addr = 5'($urandom);
  endtask

  initial begin
    logic [31:0] held_pc;
    idle_inputs();

    // Reset overrides a valid instruction with all control bits set.
    i_reset = 0; i_valid = 1; i_ctrl = 12'hFFF; rand_data();
    i_rs_addr = 3; i_rt_addr = 4;
    @(posedge i_clk);
    #1;
    model_clear();
    m_count = 0;
    compare_outputs();
    check("rst_valid", o_valid, 0);
    check("rst_ctrl", o_ctrl, 0);

    // Basic load, one-cycle latency.
    idle_inputs(); rand_data();
    i_valid = 1; i_ext_imm = 32'hFFFF8000; i_rd_addr = 5; i_ctrl = 12'h002;
    step();
    check("load_imm", o_ext_imm, 32'hFFFF8000);
    check("load_rd", o_rd_addr, 5);
    check("load_valid", o_valid, 1);

    // Load-use: a load writing $8, followed by a reader of $8.
    rand_data(); i_valid = 1; i_ctrl = 12'h001; i_rt_addr = 8; i_rs_addr = 1;
    step();
    rand_data(); i_valid = 1; i_ctrl = 12'h002; i_rs_addr = 8; i_rt_addr = 9;
    #1;
    check("lu_hit", o_load_use, 1);
    step();
    check("lu_bubble_valid", o_valid, 0);
    check("lu_bubble_ctrl", o_ctrl, 0);
    #1;
    check("lu_fall", o_load_use, 0);
    step();
    check("lu_reload_valid", o_valid, 1);
    check("lu_reload_rs", o_rs_addr, 8);

    // Same shape with the load targeting $zero: never a hazard.
    rand_data(); i_valid = 1; i_ctrl = 12'h001; i_rt_addr = 0; i_rs_addr = 2;
    step();
    rand_data(); i_valid = 1; i_ctrl = 12'h002; i_rs_addr = 0; i_rt_addr = 0;
    #1;
    check("lu_zero", o_load_use, 0);
    step();
    check("lu_zero_valid", o_valid, 1);

    // Stall holds for three cycles, then flush during stall clears.
    rand_data(); i_valid = 1; i_ctrl = 12'h0A2; i_rs_addr = 3; i_rt_addr = 4;
    step();
    held_pc = o_pc;
    for (int k = 0; k < 3; k++) begin
      rand_data(); i_stall = 1; i_ctrl = 12'h5A5;
      step();
      check("stall_pc", o_pc, held_pc);
    end
    i_flush = 1;
    step();
    check("flush_valid", o_valid, 0);
    check("flush_pc", o_pc, 0);
    i_flush = 0; i_stall = 0;

    // Bubble and flush do not count as loads in the debug counter.
    i_reset = 0; step(); i_reset = 1;
    for (int k = 0; k < 4; k++) begin
      rand_data(); i_valid = 1; i_ctrl = 12'h002; i_rs_addr = 1; i_rt_addr = 2;
      step();
    end
    i_flush = 1; step(); i_flush = 0;
    i_ctrl = 12'h001; i_rt_addr = 7; step();  // valid load -> counts
    i_ctrl = 12'h000; i_rs_addr = 7; step();  // bubble -> no count
`ifdef ID_EX_DEBUG_EN
    check("dbg_after_mix", o_dbg_count, 5);
`endif

    // Randomized traffic with a narrow register range so hazards are common.
    for (int n = 0; n < 400; n++) begin
      rand_data();
      i_reset   = ($urandom_range(0, 29) != 0);
      i_flush   = ($urandom_range(0, 9) == 0);
      i_stall   = ($urandom_range(0, 4) == 0);
      i_valid   = ($urandom_range(0, 5) != 0);
      i_ctrl    = 12'($urandom);
      i_rs_addr = 5'($urandom_range(0, 3));
      i_rt_addr = 5'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL expose parameter NBITS, default 32, as the datapath word width.
REQ-002 The block SHALL expose parameter CTRL_BITS, default 12, as the control bundle width; bit 0 = mem_read, bit 1 = reg_write.
REQ-003 The block SHALL have i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have i_reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising i_clk).
REQ-005 The block SHALL have i_valid  input  1  decode stage presents a real instruction.
REQ-006 The block SHALL have i_stall  input  1  downstream hold request.
REQ-007 The block SHALL have i_flush  input  1  branch/jump squash request.
REQ-008 The block SHALL have i_pc, i_rs_data, i_rt_data, i_ext_imm  input  NBITS each  PC+4, register file operands, extended immediate from the sign extender.
REQ-009 The block SHALL have i_rs_addr, i_rt_addr, i_rd_addr  input  5 each  register specifiers.
REQ-010 The block SHALL have i_ctrl  input  CTRL_BITS  decoded control bundle.
REQ-011 The block SHALL have o_pc, o_rs_data, o_rt_data, o_ext_imm, o_rs_addr, o_rt_addr, o_rd_addr, o_ctrl, o_valid  output  widths matching their inputs (o_valid 1)  registered copies.
REQ-012 The block SHALL have o_load_use  output  1  combinational load-use hazard flag; upstream holds PC and IF/ID while high.

Function
REQ-013 Per rising edge, priority SHALL be: reset > flush > stall > load-use bubble > load.
REQ-014 Load: when none of reset, flush, stall, o_load_use is active, every o_* SHALL take its i_* value on the edge; latency exactly 1 cycle.
REQ-015 Flush: all outputs SHALL be cleared to 0 (bubble) on the edge, regardless of i_stall or i_valid.
REQ-016 Stall: all outputs SHALL hold their current value; flush during stall still clears.
REQ-017 o_load_use SHALL equal o_valid AND o_ctrl[0] AND i_valid AND (o_rt_addr != 0) AND (o_rt_addr == i_rs_addr OR o_rt_addr == i_rt_addr).
REQ-018 Bubble: when o_load_use is 1 and neither reset, flush nor stall is active, the edge SHALL clear o_valid and o_ctrl to 0; the data/address outputs MAY update but SHALL be ignored downstream.
REQ-019 After a bubble, o_load_use SHALL fall (o_valid = 0), so the held instruction loads on the following edge; a load-use therefore costs exactly one bubble cycle.
REQ-020 i_valid = 0 with no other event SHALL load o_valid = 0 and o_ctrl = 0.
REQ-021 o_load_use SHALL evaluate during stall but SHALL NOT alter the held contents.

Reset
REQ-022 With i_reset = 0 at a rising edge, every output register SHALL become 0 (o_valid = 0, o_ctrl = 0), overriding all other inputs.
REQ-023 Reset asserted mid-stall or mid-bubble SHALL discard held state; first edge after release behaves per REQ-013.

Configuration
REQ-024 Macro ID_EX_DEBUG_EN SHALL, when defined, add output o_dbg_count (32 bits), incremented by 1 on each edge that loads o_valid = 1, wrapping 0xFFFFFFFF -> 0, cleared by reset; flushes, bubbles and stalls do not count.
REQ-025 Without ID_EX_DEBUG_EN, o_dbg_count and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-026 Reset: drive i_reset = 0 with i_valid = 1, i_ctrl = 0xFFF -> all outputs 0 next edge.
REQ-027 Load: i_valid = 1, i_ext_imm = 0xFFFF8000, i_rd_addr = 5 -> o_ext_imm = 0xFFFF8000, o_rd_addr = 5, o_valid = 1 after one edge.
REQ-028 Load-use: o_ctrl[0] = 1, o_rt_addr = 8, next i_rs_addr = 8 -> o_load_use = 1, one bubble (o_valid = 0), then instruction loads and o_load_use = 0; repeat with o_rt_addr = 0 -> no hazard.
REQ-029 Stall+flush: i_stall = 1 for 3 cycles -> outputs constant; assert i_flush with i_stall = 1 -> outputs 0 next edge.
REQ-030 Debug (ID_EX_DEBUG_EN): 4 valid loads, 1 flush, 1 bubble -> o_dbg_count = 4; preload 0xFFFFFFFF and load once -> 0.
